adaptive_delta_mod: RTL

//   Parametrised adaptive delta modulator (CVSD-style), successor to the fixed-step 8-bit DeltaMod.
//   - Per accepted sample: compares the signed input against an internal integrator (built-in comparator).
//   - Emits one bit per sample and grows or shrinks the integrator step from the recent bit history.
//   - Sits between the sampler and the serial bit channel; approx_out feeds a demodulator model and scope dumps.

---
 rtl/adm_pkg.sv | 41 ++++
 rtl/adaptive_delta_mod_step_ctrl.sv | 98 +++++++++
 rtl/adaptive_delta_mod.sv | 106 ++++++++++
 3 files changed

// File: rtl/adm_pkg.sv
// ----------------------------------------------------------------------------
// adm_pkg
//   Shared types and helpers for the adaptive delta modulator.
//   - step_state_t : which branch of the step logic produced the current step
//   - sat_add      : signed add with clamp to a width-bit two's complement range
// ----------------------------------------------------------------------------
package adm_pkg;

   typedef enum logic [1:0] {
      FIRST  = 2'd0,
      HOLD   = 2'd1,
      GROW   = 2'd2,
      SHRINK = 2'd3
   } step_state_t;

   // Working width for sat_add; callers sign-extend into it.
   localparam int SAT_W = 32;

   // The sum is formed one bit wider than the operands so it can never wrap.
   // It is then clamped to [-2^(width-1), 2^(width-1)-1].
   function automatic logic signed [SAT_W-1:0] sat_add(
      input logic signed [SAT_W-1:0] a,
      input logic signed [SAT_W-1:0] b,
      input int                      width
   );
      logic signed [SAT_W:0] sum;
      logic signed [SAT_W:0] hi;
      logic signed [SAT_W:0] lo;
      sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
      hi  = ((SAT_W+1)'(1) << (width - 1)) - (SAT_W+1)'(1);
      lo  = -hi - (SAT_W+1)'(1);
      if (sum > hi) begin
         return hi[SAT_W-1:0];
      end else if (sum < lo) begin
         return lo[SAT_W-1:0];
      end else begin
         return sum[SAT_W-1:0];
      end
   endfunction

endpackage

// File: rtl/adaptive_delta_mod_step_ctrl.sv
// ----------------------------------------------------------------------------
// adm_step_ctrl
//   Step-size controller for the adaptive delta modulator. Tracks the run of
//   equal output bits and doubles the step on a long run, halves it on a bit
//   flip. step_n is the combinational step for the sample being accepted;
//   step/state are registered on the strobe.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   FIRST  | no sample accepted since reset
//   HOLD   | last sample kept the step unchanged
//   GROW   | last sample doubled the step (run reached RUN_LEN)
//   SHRINK | last sample halved the step (bit differed from previous)
//
// Ports
//   clk_in  in   1      system clock
//   rst_n   in   1      async active-low reset
//   strobe  in   1      sample accepted this edge
//   b       in   1      comparator result for the sample being accepted
//   step_n  out  WIDTH  step that applies to this sample (combinational)
//   step    out  WIDTH  registered current step
//   state   out  2      branch taken on the last accepted sample (debug)
// ----------------------------------------------------------------------------
module adm_step_ctrl
   import adm_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int STEP_MIN = 1,
   parameter int STEP_MAX = 64,
   parameter int RUN_LEN  = 3
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             strobe,
   input  logic             b,
   output logic [WIDTH-1:0] step_n,
   output logic [WIDTH-1:0] step,
   output step_state_t      state
);

   localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(STEP_MIN);
   localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(STEP_MAX);
   localparam logic [3:0]       RUN_MAX = 4'(RUN_LEN);

   logic [3:0]       run_cnt;
   logic [3:0]       run_cnt_n;
   logic             prev_bit;
   logic             first;
   logic             flip;
   logic [WIDTH:0]   step_dbl;
   logic [WIDTH-1:0] step_half;
   step_state_t      branch;

   assign flip      = !first && (b != prev_bit);
   assign step_dbl  = {step, 1'b0};
   assign step_half = step >> 1;

   // Run length saturates at RUN_LEN so a long run keeps re-triggering growth.
   always_comb begin
      run_cnt_n = run_cnt;
      if (first || (b != prev_bit)) begin
         run_cnt_n = 4'd1;
      end else if (run_cnt < RUN_MAX) begin
         run_cnt_n = run_cnt + 4'd1;
      end else begin
         run_cnt_n = RUN_MAX;
      end
   end

   always_comb begin
      branch = HOLD;
      step_n = step;
      if (flip) begin
         branch = SHRINK;
         step_n = (step_half < MIN_W) ? MIN_W : step_half;
      end else if (run_cnt_n == RUN_MAX) begin
         branch = GROW;
         step_n = (step_dbl > MAX_X) ? MAX_X[WIDTH-1:0] : step_dbl[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt  <= 4'd0;
         prev_bit <= 1'b0;
         first    <= 1'b1;
         step     <= MIN_W;
         state    <= FIRST;
      end else if (strobe) begin
         run_cnt  <= run_cnt_n;
         prev_bit <= b;
         first    <= 1'b0;
         step     <= step_n;
         state    <= branch;
      end
   end

endmodule

// File: rtl/adaptive_delta_mod.sv
// ----------------------------------------------------------------------------
// adaptive_delta_mod
//   CVSD-style adaptive delta modulator. Each accepted sample is compared
//   with the integrator; the resulting bit is emitted and the integrator moves
//   one (adaptive) step toward the sample, saturating at full scale.
//
//   Build option: define ADM_LEAK_EN to make the integrator leak toward zero
//   by approx>>>LEAK_SHIFT on every accepted sample (idle-tone suppression).
//   Without it LEAK_SHIFT has no effect.
//
// Ports
//   clk_in        in   1      system clock, rising edge
//   rst_n         in   1      async active-low reset
//   sample_valid  in   1      sample_in accepted on this edge
//   sample_in     in   WIDTH  signed sample
//   bit_out       out  1      1 = sample was above the integrator
//   bit_valid     out  1      one-cycle strobe after an accepted sample
//   approx_out    out  WIDTH  signed integrator (staircase approximation)
//   step_out      out  WIDTH  current step size, unsigned
//   step_state    out  2      step branch of the last sample (debug only)
// ----------------------------------------------------------------------------
module adaptive_delta_mod
   import adm_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int STEP_MIN   = 1,
   parameter int STEP_MAX   = 64,
   parameter int RUN_LEN    = 3,
   parameter int LEAK_SHIFT = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_n,
   input  logic                    sample_valid,
   input  logic signed [WIDTH-1:0] sample_in,
   output logic                    bit_out,
   output logic                    bit_valid,
   output logic signed [WIDTH-1:0] approx_out,
   output logic        [WIDTH-1:0] step_out,
   output step_state_t             step_state
);

   if (STEP_MIN < 1 || STEP_MAX < STEP_MIN || STEP_MAX > (2 ** (WIDTH - 1)) - 1 ||
       RUN_LEN < 2 || RUN_LEN > 15 || LEAK_SHIFT < 0 || LEAK_SHIFT >= WIDTH ||
       WIDTH >= SAT_W) begin : g_bad_params
      $error("adaptive_delta_mod: parameter out of range");
   end

   logic signed [WIDTH-1:0] approx;
   logic signed [WIDTH-1:0] approx_n;
   logic        [WIDTH-1:0] step_n;
   logic        [WIDTH-1:0] step;
   logic                    b;
   logic signed [SAT_W-1:0] approx_x;
   logic signed [SAT_W-1:0] step_x;
   logic signed [SAT_W-1:0] base_x;
   logic signed [SAT_W-1:0] delta_x;

   // Built-in comparator; a tie counts as "not above".
   assign b = sample_in > approx;

   adm_step_ctrl #(
      .WIDTH    (WIDTH),
      .STEP_MIN (STEP_MIN),
      .STEP_MAX (STEP_MAX),
      .RUN_LEN  (RUN_LEN)
   ) u_step_ctrl (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .strobe (sample_valid),
      .b      (b),
      .step_n (step_n),
      .step   (step),
      .state  (step_state)
   );

   assign approx_x = {{(SAT_W-WIDTH){approx[WIDTH-1]}}, approx};
   assign step_x   = {{(SAT_W-WIDTH){1'b0}}, step_n};
   assign delta_x  = b ? step_x : -step_x;

`ifdef ADM_LEAK_EN
   // Leak always moves toward zero, so base_x stays inside the WIDTH range.
   assign base_x = approx_x - (approx_x >>> LEAK_SHIFT);
`else
   assign base_x = approx_x;
`endif

   assign approx_n = WIDTH'(sat_add(base_x, delta_x, WIDTH));

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         approx    <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
      end else begin
         bit_valid <= sample_valid;
         if (sample_valid) begin
            approx  <= approx_n;
            bit_out <= b;
         end
      end
   end

   assign approx_out = approx;
   assign step_out   = step;

endmodule
